cast_output_stage: RTL and testbench

- Per-port egress stage of the cast router. It sits downstream of the crossbar and consumes the flit stream that the input stage forwards through it.
- Buffers flits in a 2-entry skid buffer, so ready_o toward the crossbar is registered.
- Tracks credits for the downstream input FIFO and emits flits onto the link only when a credit is available.
- Tracks packet framing and pulses a VC-release to the vc_allocator when a tail flit leaves.

---
 rtl/cast_pkg.sv | 23 ++
 rtl/cast_skid_buffer.sv | 61 ++++++
 rtl/cast_output_stage.sv | 121 ++++++++++++
 tb/tb_cast_output_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cast_pkg.sv
// rtl/cast_pkg.sv - shared flit-type constants, out-stage FSM enum and router width macros
`ifndef CAST_ROUTER_BUFFER_DEPTH_LOG
`define CAST_ROUTER_BUFFER_DEPTH_LOG 4
`endif
`ifndef DW
`define DW 32
`endif

package cast_pkg;

  typedef logic [1:0] flit_type_t;

  localparam flit_type_t FT_BODY   = 2'b00;
  localparam flit_type_t FT_TAIL   = 2'b01;
  localparam flit_type_t FT_HEAD   = 2'b10;
  localparam flit_type_t FT_SINGLE = 2'b11;

  typedef enum logic {
    OS_IDLE,
    OS_ACTIVE
  } os_state_t;

endpackage

// File: rtl/cast_skid_buffer.sv
// rtl/cast_skid_buffer.sv - 2-entry FIFO with registered ready toward the producer
module cast_skid_buffer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  input  logic         pop_i
);

  logic [W-1:0] mem_q [2];
  logic         rd_q;
  logic         wr_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic         ready_q;
  logic         acc;
  logic         pop;

  assign acc     = valid_i & ready_q;
  assign pop     = pop_i & (cnt_q != 2'd0);
  assign ready_o = ready_q;
  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({acc, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // ready is derived from next occupancy so the producer never overruns the two slots
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
      ready_q  <= 1'b1;
    end else begin
      if (acc) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d < 2'd2);
    end
  end

endmodule

// File: rtl/cast_output_stage.sv
// rtl/cast_output_stage.sv - per-port egress: skid buffer, downstream credit tracking, packet framing
module cast_output_stage
  import cast_pkg::*;
#(
  parameter int CREDIT_INIT = 2 ** `CAST_ROUTER_BUFFER_DEPTH_LOG,
  parameter int CW          = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           valid_i,
  input  logic [`DW-1:0] data_i,
  output logic           ready_o,
  output logic           valid_o,
  output logic [`DW-1:0] data_o,
  input  logic           ready_i,
  input  logic           credit_i,
  output logic           vc_release_o,
  output logic [CW-1:0]  credit_cnt_o,
  output logic           in_pkt_o,
  output logic           err_o
);

  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDIT_INIT);

  logic           buf_valid;
  logic [`DW-1:0] buf_data;
  logic           send;
  flit_type_t     ftype;

  logic [CW-1:0]  credit_q, credit_d;
  os_state_t      state_q, state_d;
  logic           rel_q, rel_d;
  logic           err_q, err_d;
  logic           cred_err;
  logic           frm_err;

  cast_skid_buffer #(
    .W(`DW)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (buf_valid),
    .data_o  (buf_data),
    .pop_i   (send)
  );

  assign valid_o      = buf_valid & (credit_q != '0);
  assign data_o       = buf_data;
  assign send         = valid_o & ready_i;
  assign ftype        = flit_type_t'(buf_data[`DW-1:`DW-2]);
  assign credit_cnt_o = credit_q;
  assign vc_release_o = rel_q;
  assign in_pkt_o     = (state_q == OS_ACTIVE);
  assign err_o        = err_q;

  always_comb begin
    credit_d = credit_q;
    cred_err = 1'b0;
    case ({send, credit_i})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CREDIT_MAX) cred_err = 1'b1;
        else                        credit_d = credit_q + 1'b1;
      end
      default: credit_d = credit_q;
    endcase
  end

  // out-of-order HEAD/SINGLE while ACTIVE is flagged but still starts a new packet
  always_comb begin
    state_d = state_q;
    rel_d   = 1'b0;
    frm_err = 1'b0;
    if (send) begin
      case (state_q)
        OS_IDLE: begin
          case (ftype)
            FT_HEAD:   state_d = OS_ACTIVE;
            FT_SINGLE: rel_d   = 1'b1;
            default:   frm_err = 1'b1;
          endcase
        end
        OS_ACTIVE: begin
          case (ftype)
            FT_BODY: state_d = OS_ACTIVE;
            FT_TAIL: begin
              state_d = OS_IDLE;
              rel_d   = 1'b1;
            end
            FT_HEAD: frm_err = 1'b1;
            default: begin
              frm_err = 1'b1;
              state_d = OS_IDLE;
              rel_d   = 1'b1;
            end
          endcase
        end
        default: state_d = OS_IDLE;
      endcase
    end
    err_d = err_q | cred_err | frm_err;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit_q <= CREDIT_MAX;
      state_q  <= OS_IDLE;
      rel_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      state_q  <= state_d;
      rel_q    <= rel_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_cast_output_stage.sv
// tb/tb_cast_output_stage.sv - directed self-checking bench for cast_output_stage
module tb_cast_output_stage;
  import cast_pkg::*;

  logic           clk      = 1'b0;
  logic           rstn     = 1'b0;
  logic           valid_i  = 1'b0;
  logic [`DW-1:0] data_i   = '0;
  logic           ready_i  = 1'b0;
  logic           credit_i = 1'b0;
  logic           ready_o;
  logic           valid_o;
  logic [`DW-1:0] data_o;
  logic           vc_release_o;
  logic [15:0]    credit_cnt_o;
  logic           in_pkt_o;
  logic           err_o;

  cast_output_stage dut (
    .clk          (clk),
    .rstn         (rstn),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .ready_i      (ready_i),
    .credit_i     (credit_i),
    .vc_release_o (vc_release_o),
    .credit_cnt_o (credit_cnt_o),
    .in_pkt_o     (in_pkt_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int vc_cnt   = 0;
  bit inpkt_seen = 1'b0;
  int tx_idx   = 0;
  int cmin, cmax, v0;
  logic [`DW-1:0] tx [$];
  logic [`DW-1:0] rx [$];

  always @(negedge clk) begin
    if (vc_release_o) vc_cnt++;
    if (in_pkt_o) inpkt_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [`DW-1:0] mk(input flit_type_t t, input int p);
    logic [`DW-3:0] pl;
    pl = p[`DW-3:0];
    return {t, pl};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_i  = 1'b0;
      credit_i = 1'b0;
      data_i   = '0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0; valid_i = 1'b0; ready_i = 1'b0; credit_i = 1'b0; data_i = '0;
    tx.delete(); rx.delete(); tx_idx = 0; inpkt_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // rmode 1 toggles ready_i; cmode 1 returns a credit on every send, cmode 2 pulses once
  task automatic run(input int rmode, input int cmode, input int budget, input bit stop);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      valid_i  = (tx_idx < tx.size());
      data_i   = valid_i ? tx[tx_idx] : '0;
      ready_i  = (rmode == 1) ? c[0] : 1'b1;
      credit_i = (cmode == 1) ? (valid_o & ready_i) : ((cmode == 2) && (c == 0));
      @(negedge clk);
      if (valid_i && ready_o) tx_idx++;
      if (valid_o && ready_i) rx.push_back(data_o);
      if (int'(credit_cnt_o) < cmin) cmin = int'(credit_cnt_o);
      if (int'(credit_cnt_o) > cmax) cmax = int'(credit_cnt_o);
      if (stop && rx.size() == tx.size()) break;
    end
  endtask

  task automatic load_pkt(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      if (i == 0)          tx.push_back(mk(FT_HEAD, base + i));
      else if (i == n - 1) tx.push_back(mk(FT_TAIL, base + i));
      else                 tx.push_back(mk(FT_BODY, base + i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    do_reset();
    @(negedge clk);
    check_eq("rst_valid", valid_o, 1'b0);
    check_eq("rst_ready", ready_o, 1'b1);
    check_eq("rst_credit", credit_cnt_o, 16);
    check_eq("rst_data", data_o, 0);
    check_eq("rst_inpkt", in_pkt_o, 1'b0);
    check_eq("rst_err", err_o, 1'b0);
    check_eq("rst_rel", vc_release_o, 1'b0);

    // HEAD, BODY, TAIL back to back
    v0 = vc_cnt;
    @(posedge clk); #1; valid_i = 1'b1; data_i = mk(FT_HEAD, 1); ready_i = 1'b1;
    @(negedge clk); check_eq("hbt_ready", ready_o, 1'b1);
    check_eq("hbt_lat0_valid", valid_o, 1'b0);
    @(posedge clk); #1; data_i = mk(FT_BODY, 2);
    @(negedge clk); check_eq("hbt_v1", valid_o, 1'b1);
    check_eq("hbt_d1", data_o, mk(FT_HEAD, 1));
    check_eq("hbt_inpkt0", in_pkt_o, 1'b0);
    @(posedge clk); #1; data_i = mk(FT_TAIL, 3);
    @(negedge clk); check_eq("hbt_d2", data_o, mk(FT_BODY, 2));
    check_eq("hbt_inpkt1", in_pkt_o, 1'b1);
    @(posedge clk); #1; valid_i = 1'b0; data_i = '0;
    @(negedge clk); check_eq("hbt_d3", data_o, mk(FT_TAIL, 3));
    check_eq("hbt_v3", valid_o, 1'b1);
    check_eq("hbt_rel_early", vc_release_o, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); check_eq("hbt_v4", valid_o, 1'b0);
    check_eq("hbt_rel", vc_release_o, 1'b1);
    check_eq("hbt_credit", credit_cnt_o, 13);
    check_eq("hbt_inpkt_end", in_pkt_o, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); check_eq("hbt_rel_off", vc_release_o, 1'b0);
    check_eq("hbt_rel_cnt", vc_cnt - v0, 1);

    // credit exhaustion
    do_reset();
    load_pkt(20, 200);
    run(0, 0, 30, 1'b0);
    check_eq("exh_sent", rx.size(), 16);
    check_eq("exh_credit", credit_cnt_o, 0);
    check_eq("exh_valid", valid_o, 1'b0);
    check_eq("exh_ready", ready_o, 1'b0);
    check_eq("exh_acc", tx_idx, 18);
    run(0, 2, 6, 1'b0);
    check_eq("exh_one_more", rx.size(), 17);
    check_eq("exh_credit2", credit_cnt_o, 0);
    check_eq("exh_err", err_o, 1'b0);
    for (int i = 0; i < 17; i++) check_eq($sformatf("exh_order%0d", i), rx[i], tx[i]);

    // credit returned on every send cycle
    do_reset();
    v0 = vc_cnt;
    load_pkt(10, 300);
    cmin = 1000; cmax = -1;
    run(0, 1, 40, 1'b1);
    idle(2);
    check_eq("sim_sent", rx.size(), 10);
    check_eq("sim_cmin", cmin, 16);
    check_eq("sim_cmax", cmax, 16);
    check_eq("sim_credit", credit_cnt_o, 16);
    check_eq("sim_err", err_o, 1'b0);
    check_eq("sim_rel", vc_cnt - v0, 1);

    // ready_i toggling
    do_reset();
    v0 = vc_cnt;
    load_pkt(10, 400);
    run(1, 0, 60, 1'b1);
    idle(2);
    check_eq("tog_sent", rx.size(), 10);
    for (int i = 0; i < 10 && i < rx.size(); i++) check_eq($sformatf("tog_order%0d", i), rx[i], tx[i]);
    check_eq("tog_credit", credit_cnt_o, 6);
    check_eq("tog_rel", vc_cnt - v0, 1);
    check_eq("tog_inpkt", in_pkt_o, 1'b0);

    // SINGLE, then BODY while idle
    do_reset();
    v0 = vc_cnt;
    tx.push_back(mk(FT_SINGLE, 500));
    run(0, 0, 10, 1'b1);
    idle(3);
    check_eq("sgl_rel", vc_cnt - v0, 1);
    check_eq("sgl_inpkt_never", inpkt_seen, 1'b0);
    check_eq("sgl_err", err_o, 1'b0);
    tx.push_back(mk(FT_BODY, 501));
    run(0, 0, 10, 1'b1);
    idle(1);
    @(negedge clk); check_eq("body_idle_err", err_o, 1'b1);
    idle(5);
    @(negedge clk); check_eq("body_idle_sticky", err_o, 1'b1);
    check_eq("body_idle_inpkt", in_pkt_o, 1'b0);
    check_eq("body_idle_rel", vc_cnt - v0, 1);

    // credit overflow
    do_reset();
    @(negedge clk); check_eq("ovf_err_pre", err_o, 1'b0);
    @(posedge clk); #1; credit_i = 1'b1;
    @(posedge clk); #1; credit_i = 1'b0;
    @(negedge clk); check_eq("ovf_err", err_o, 1'b1);
    check_eq("ovf_credit", credit_cnt_o, 16);

    // mid-packet reset
    do_reset();
    v0 = vc_cnt;
    @(posedge clk); #1; valid_i = 1'b1; data_i = mk(FT_HEAD, 600); ready_i = 1'b1;
    @(posedge clk); #1; data_i = mk(FT_BODY, 601);
    @(posedge clk); #1; data_i = mk(FT_BODY, 602); ready_i = 1'b0;
    @(posedge clk); #1; valid_i = 1'b0; data_i = '0;
    @(negedge clk);
    check_eq("mid_inpkt", in_pkt_o, 1'b1);
    check_eq("mid_ready", ready_o, 1'b0);
    check_eq("mid_credit", credit_cnt_o, 15);
    #2 rstn = 1'b0;
    #1;
    check_eq("mid_rst_valid", valid_o, 1'b0);
    check_eq("mid_rst_ready", ready_o, 1'b1);
    check_eq("mid_rst_credit", credit_cnt_o, 16);
    check_eq("mid_rst_inpkt", in_pkt_o, 1'b0);
    check_eq("mid_rst_data", data_o, 0);
    @(posedge clk); #1 rstn = 1'b1;
    idle(2);
    check_eq("mid_no_rel", vc_cnt - v0, 0);
    tx.delete(); rx.delete(); tx_idx = 0;
    load_pkt(2, 700);
    run(0, 0, 20, 1'b1);
    idle(3);
    check_eq("mid_post_sent", rx.size(), 2);
    for (int i = 0; i < 2 && i < rx.size(); i++) check_eq($sformatf("mid_post_order%0d", i), rx[i], tx[i]);
    check_eq("mid_post_rel", vc_cnt - v0, 1);
    check_eq("mid_post_credit", credit_cnt_o, 14);
    check_eq("mid_post_err", err_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
